fifo_word_reader: RTL and testbench
===================================

// Module: fifo_word_reader
// PURPOSE
//  Read-side controller for the 8-bit fifo: drains bytes via the fifo read request,
//  packs BYTES consecutive bytes little-endian into one word, presents it on a
//  valid/ready master port. Sits between the byte fifo and a word-wide consumer.
// PARAMETERS
//  BYTES         4   bytes packed per output word (2..8)
//  FLUSH_CYCLES  16  idle cycles before a partial word is flushed (FLUSH_TIMEOUT_EN only)
// PORTS
//  clk           in   1          clock, all logic on posedge
//  resetn        in   1          synchronous reset, active-high (asserted = 1)
//  fifo_isempty  in   1          fifo empty flag
//  fifo_wr_busy  in   1          mirror of fifo write request; fifo ignores reads while high
//  rdata         in   8          fifo read data, valid the cycle after an accepted read
//  o_rreq        out  1          read request to fifo (drives fifo i_rreq)
//  m_data        out  8*BYTES    packed word; first byte read in [7:0]
//  m_bytes       out  $clog2(BYTES)+1  valid byte count in m_data (1..BYTES)
//  m_valid       out  1          word available
//  m_ready       in   1          consumer accepts word when m_valid && m_ready
// BEHAVIOUR
//  Reset (resetn=1 at posedge): state=IDLE, o_rreq=0, m_valid=0, m_data=0, m_bytes=0,
//   byte count cnt=0, idle timer=0. Reset overrides everything, incl. mid-word/mid-OUT;
//   partial bytes are discarded.
//  FSM (registered state; o_rreq = (state==RD), m_valid = (state==OUT)):
//   IDLE: !fifo_isempty && !fifo_wr_busy -> RD; else stay.
//   RD:   o_rreq=1 exactly one cycle. fifo_wr_busy high this cycle -> read not
//         accepted -> IDLE (retry, cnt unchanged). Else -> CAP.
//   CAP:  lane[cnt] <= rdata; cnt <= cnt+1. cnt==BYTES-1 -> OUT with m_bytes=BYTES;
//         else -> IDLE.
//   OUT:  m_data/m_bytes stable while m_valid && !m_ready. On handshake: cnt<=0,
//         m_data<=0, -> IDLE. No fifo reads issued in OUT (backpressure holds fifo).
//  Latency: byte sampled 2 cycles after fifo_isempty seen low in IDLE; min 3 cycles/byte;
//   m_valid rises the cycle after the last CAP.
//  Never more than one read outstanding; o_rreq never asserted while fifo_isempty
//   was seen high in IDLE -> no underflow.
//  Lanes filled in order 0..BYTES-1; unfilled lanes read as 0.
//  cnt width $clog2(BYTES)+1; wraps only via handshake clear, never arithmetically.
//  fifo_isempty rising during CAP: word stays partial, block waits in IDLE.
// CONFIGURATION
//  FLUSH_TIMEOUT_EN defined: in IDLE with cnt>0 and fifo_isempty=1, idle timer counts
//   up; any cycle with fifo_isempty=0 or state!=IDLE clears it. Timer reaching
//   FLUSH_CYCLES -> OUT with m_bytes=cnt, timer cleared. cnt==0 never flushes.
//  FLUSH_TIMEOUT_EN undefined: no timer logic; partial word held indefinitely;
//   m_bytes always BYTES when m_valid. FLUSH_CYCLES unused.
// TESTING
//  1 fifo holds 11,22,33,44, m_ready=1 -> one word m_data=0x44332211, m_bytes=4,
//    exactly 4 single-cycle o_rreq pulses, fifo empty after.
//  2 8 bytes 01..08, m_ready=0 for 20 cycles -> m_valid held, m_data=0x04030201
//    stable, no o_rreq during OUT; release -> second word 0x08070605.
//  3 fifo_wr_busy=1 in the RD cycle of byte 2 -> that read retried, final word
//    still 0x44332211, no byte duplicated or lost.
//  4 resetn=1 after 2 bytes captured -> all outputs 0 next cycle; next 4 bytes
//    AA,BB,CC,DD -> 0xDDCCBBAA.
//  5 FLUSH_TIMEOUT_EN, 2 bytes 5A,A5 then empty -> m_valid after 16 idle cycles,
//    m_data=0x0000A55A, m_bytes=2; without macro -> m_valid stays 0.
//  6 fifo empty from reset, 100 cycles -> o_rreq never asserted, m_valid=0.

Source files
------------

// File: rtl/fifo_word_reader_if.sv
// Word-side valid/ready bundle of fifo_word_reader.
// m_bytes carries the valid byte count of m_data.
interface fifo_word_reader_if #(
  parameter int BYTES = 4
);
  localparam int CW = $clog2(BYTES) + 1;

  logic [8*BYTES-1:0] m_data;
  logic [CW-1:0]      m_bytes;
  logic               m_valid;
  logic               m_ready;

  modport master (
    output m_data,
    output m_bytes,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_bytes,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_word_reader.sv
// Drains an 8-bit fifo and packs BYTES bytes little-endian into a word.
// Define FLUSH_TIMEOUT_EN to flush partial words after FLUSH_CYCLES idle.
module fifo_word_reader #(
  parameter int BYTES        = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fifo_isempty,
  input  logic              fifo_wr_busy,
  input  logic [7:0]        rdata,
  output logic              o_rreq,
  fifo_word_reader_if.master m
);

  localparam int CW = $clog2(BYTES) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [CW-1:0] FULL = CW'(BYTES);
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  if (BYTES < 2 || BYTES > 8 || FLUSH_CYCLES < 1) begin : g_bad_cfg
    $error("fifo_word_reader: bad BYTES/FLUSH_CYCLES");
  end

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      bytes_q, bytes_d;
  logic [8*BYTES-1:0] data_q, data_d;
  logic               go_rd;
  logic               tmr_hit;

  assign go_rd = !fifo_isempty && !fifo_wr_busy;

`ifdef FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(FLUSH_CYCLES + 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmr_run;

  // Only a starved partial word ages; any activity restarts the count
  assign tmr_run = (state_q == S_IDLE) && (cnt_q != '0)
                && fifo_isempty;
  assign tmr_hit = tmr_run && (tmr_q == TW'(FLUSH_CYCLES - 1));

  always_comb begin
    tmr_d = '0;
    if (tmr_run && !tmr_hit) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (resetn) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`else
  assign tmr_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    data_d  = data_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (go_rd) begin
          state_d = S_RD;
        end else if (tmr_hit) begin
          state_d = S_OUT;
          bytes_d = cnt_q;
        end
      end
      (state_q == S_RD): begin
        state_d = fifo_wr_busy ? S_IDLE : S_CAP;
      end
      (state_q == S_CAP): begin
        for (int i = 0; i < BYTES; i++) begin
          if (cnt_q == CW'(i)) data_d[8*i +: 8] = rdata;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_OUT;
          bytes_d = FULL;
        end else begin
          state_d = S_IDLE;
        end
      end
      (state_q == S_OUT): begin
        if (m.m_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bytes_d = '0;
          data_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bytes_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
      data_q  <= data_d;
    end
  end

  assign o_rreq    = (state_q == S_RD);
  assign m.m_valid = (state_q == S_OUT);
  assign m.m_data  = data_q;
  assign m.m_bytes = bytes_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: byte-fifo model, word scoreboard,
// directed scenarios then randomized traffic with backpressure.
module tb_fifo_word_reader;

  localparam int BYTES = 4;
  localparam int FLUSH = 16;
  localparam int NWORDS = 150;

  typedef struct {
    logic [8*BYTES-1:0] d;
    int                 n;
  } word_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       fifo_isempty = 1'b1;
  logic       fifo_wr_busy = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       o_rreq;

  fifo_word_reader_if #(.BYTES(BYTES)) mif ();

  fifo_word_reader #(
    .BYTES(BYTES),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .fifo_isempty(fifo_isempty),
    .fifo_wr_busy(fifo_wr_busy),
    .rdata(rdata),
    .o_rreq(o_rreq),
    .m(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int rreq_cnt = 0;
  int hs_cnt = 0;

  logic [7:0] fq[$];
  logic [7:0] acc[$];
  word_t      expq[$];

  bit                 hold = 0;
  bit                 prev_rreq = 0;
  bit                 accept;
  logic [7:0]         b;
  logic [8*BYTES-1:0] w;

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: byte fifo model, scoreboard and per-cycle output checks
  always begin
    @(negedge clk);
    #2;
    if (!resetn) begin
      accept = o_rreq && !fifo_wr_busy;
      if (o_rreq) begin
        rreq_cnt++;
        check("rreq_single", {63'd0, prev_rreq}, 0);
        check("rreq_in_out", {63'd0, mif.m_valid}, 0);
      end
      if (accept) begin
        check("underflow", fq.size() == 0, 0);
        if (fq.size() > 0) begin
          b = fq.pop_front();
          rdata = b;
          hold = 1;
          pops++;
          acc.push_back(b);
          if (acc.size() == BYTES) begin
            w = '0;
            for (int i = 0; i < BYTES; i++) w[8*i +: 8] = acc[i];
            expq.push_back('{d: w, n: BYTES});
            acc.delete();
          end
        end
      end else if (hold) begin
        hold = 0;
      end else begin
        rdata = 8'($urandom);
      end
      if (mif.m_valid) begin
        check("word_pending", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          check("m_data", mif.m_data, expq[0].d);
          check("m_bytes", mif.m_bytes, expq[0].n);
          if (mif.m_ready) begin
            void'(expq.pop_front());
            hs_cnt++;
          end
        end
      end
      prev_rreq = o_rreq;
    end else begin
      prev_rreq = 0;
      hold = 0;
    end
    fifo_isempty = (fq.size() == 0);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pops(int n, string name);
    int k = 0;
    while (pops < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, pops >= n, 1);
  endtask

  task automatic wait_valid(string name);
    int k = 0;
    while (!mif.m_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, {63'd0, mif.m_valid}, 1);
  endtask

  task automatic do_reset(string name);
    resetn = 1'b1;
    cyc(2);
    check({name, "_rreq"}, {63'd0, o_rreq}, 0);
    check({name, "_valid"}, {63'd0, mif.m_valid}, 0);
    check({name, "_data"}, mif.m_data, 0);
    check({name, "_bytes"}, mif.m_bytes, 0);
    fq.delete();
    acc.delete();
    expq.delete();
    resetn = 1'b0;
  endtask

  task automatic rnd_cycle();
    @(negedge clk);
    mif.m_ready  = ($urandom % 4) != 0;
    fifo_wr_busy = ($urandom % 5) == 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int r0, r1, p0, vc, st, n, h0, k;
    mif.m_ready = 1'b1;
    cyc(1);
    do_reset("rst0");

    // Empty fifo: nothing may happen
    r0 = rreq_cnt;
    vc = 0;
    repeat (100) begin
      @(negedge clk);
      if (mif.m_valid) vc++;
    end
    check("t6_rreq", rreq_cnt - r0, 0);
    check("t6_valid", vc, 0);

    // Single word
    r0 = rreq_cnt;
    fq.push_back(8'h11); fq.push_back(8'h22);
    fq.push_back(8'h33); fq.push_back(8'h44);
    wait_valid("t1_valid");
    check("t1_data", mif.m_data, 32'h44332211);
    check("t1_bytes", mif.m_bytes, 4);
    cyc(3);
    check("t1_rreq", rreq_cnt - r0, 4);
    check("t1_empty", fq.size(), 0);

    // Backpressure holds the word and the fifo
    mif.m_ready = 1'b0;
    r0 = rreq_cnt;
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
    wait_valid("t2_valid1");
    check("t2_data1", mif.m_data, 32'h04030201);
    r1 = rreq_cnt;
    st = 0;
    repeat (20) begin
      @(negedge clk);
      if (mif.m_valid && mif.m_data == 32'h04030201) st++;
    end
    check("t2_hold", st, 20);
    check("t2_no_rreq", rreq_cnt - r1, 0);
    mif.m_ready = 1'b1;
    cyc(1);
    wait_valid("t2_valid2");
    check("t2_data2", mif.m_data, 32'h08070605);
    cyc(3);
    check("t2_rreq", rreq_cnt - r0, 8);

    // Write-busy during the read of byte 2 forces a retry
    r0 = rreq_cnt;
    p0 = pops;
    fq.push_back(8'h11); fq.push_back(8'h22);
    fq.push_back(8'h33); fq.push_back(8'h44);
    wait_pops(p0 + 1, "t3_pop1");
    k = 0;
    while (!o_rreq && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t3_rd_seen", {63'd0, o_rreq}, 1);
    fifo_wr_busy = 1'b1;
    cyc(1);
    fifo_wr_busy = 1'b0;
    wait_valid("t3_valid");
    check("t3_data", mif.m_data, 32'h44332211);
    cyc(3);
    check("t3_rreq", rreq_cnt - r0, 5);
    check("t3_pops", pops - p0, 4);

    // Reset mid-word discards the partial bytes
    p0 = pops;
    fq.push_back(8'h77); fq.push_back(8'h66);
    wait_pops(p0 + 2, "t4_pops");
    cyc(3);
    do_reset("t4_rst");
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    fq.push_back(8'hCC); fq.push_back(8'hDD);
    wait_valid("t4_valid");
    check("t4_data", mif.m_data, 32'hDDCCBBAA);
    check("t4_bytes", mif.m_bytes, 4);
    cyc(3);

    // Starved partial word
    p0 = pops;
    fq.push_back(8'h5A); fq.push_back(8'hA5);
    wait_pops(p0 + 2, "t5_pops");
    n = 0;
`ifdef FLUSH_TIMEOUT_EN
    acc.delete();
    expq.push_back('{d: 32'h0000A55A, n: 2});
    while (!mif.m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5_delay", n, 17);
    check("t5_data", mif.m_data, 32'h0000A55A);
    check("t5_bytes", mif.m_bytes, 2);
    cyc(3);
`else
    vc = 0;
    while (n < 40) begin
      @(negedge clk);
      if (mif.m_valid) vc++;
      n++;
    end
    check("t5_no_flush", vc, 0);
    do_reset("t5_rst");
`endif

    // Randomized traffic
    h0 = hs_cnt;
    for (int wi = 0; wi < NWORDS; wi++) begin
      repeat ($urandom_range(0, 6)) rnd_cycle();
      for (int j = 0; j < BYTES; j++) begin
        fq.push_back(8'($urandom));
        rnd_cycle();
      end
    end
    mif.m_ready  = 1'b1;
    fifo_wr_busy = 1'b0;
    k = 0;
    while ((fq.size() != 0 || expq.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("rnd_drain", fq.size() + expq.size(), 0);
    check("rnd_partial", acc.size(), 0);
    check("rnd_words", hs_cnt - h0, NWORDS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
